// File: rtl/qenc_pkg.sv
// Shared types and default parameters for the quadrature encoder array.
package qenc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        R1,
        R2,
        R3,
        ADD,
        L1,
        L2,
        L3,
        SUB
    } qenc_state_e;

    localparam int NUM_CH_DEF   = 2;
    localparam int POS_W_DEF    = 5;
    localparam int POS_MAX_DEF  = 19;
    localparam int FILT_LEN_DEF = 4;

endpackage

// File: rtl/qenc_channel.sv
// One quadrature channel: 2-flop synchroniser, optional level filter (QENC_FILTER_EN),
// detent-tracking FSM and wrapping position counter.
module qenc_channel
    import qenc_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             step_up,
    output logic             step_dn,
    output logic             dir,
    output logic             err
);

    if (POS_MAX < 1 || POS_MAX > (2 ** POS_W) - 1 || FILT_LEN < 1) begin : g_bad_param
        $error("qenc_channel: parameter out of range");
    end

    logic a_p0, a_p1, b_p0, b_p1;
    logic a_f, b_f;
    logic a_q, b_q;
    logic illegal;
    qenc_state_e state;

    function automatic qenc_state_e step_fsm(qenc_state_e s, logic av, logic bv);
        qenc_state_e n;
        n = s;
        case (s)
            IDLE:    if (!bv) n = R1; else if (!av) n = L1;
            R1:      if (!av) n = R2; else if (bv) n = IDLE;
            R2:      if (bv)  n = R3; else if (av) n = R1;
            R3:      if (av)  n = ADD; else if (!bv) n = R2;
            L1:      if (!bv) n = L2; else if (av) n = IDLE;
            L2:      if (av)  n = L3; else if (bv) n = L1;
            L3:      if (bv)  n = SUB; else if (!av) n = L2;
            ADD:     n = IDLE;
            SUB:     n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic is_right(qenc_state_e s);
        return s inside {R1, R2, R3, ADD};
    endfunction

    function automatic logic [POS_W-1:0] pos_inc(logic [POS_W-1:0] p);
        return (p == POS_W'(POS_MAX)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(logic [POS_W-1:0] p);
        return (p == '0) ? POS_W'(POS_MAX) : p - 1'b1;
    endfunction

    // Stage p0/p1: metastability synchroniser, idles at the detent level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0 <= 1'b1;
            a_p1 <= 1'b1;
            b_p0 <= 1'b1;
            b_p1 <= 1'b1;
        end else begin
            a_p0 <= a;
            a_p1 <= a_p0;
            b_p0 <= b;
            b_p1 <= b_p0;
        end
    end

`ifdef QENC_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);
    logic [CNT_W-1:0] a_cnt, b_cnt;

    // Filter stage: a new level is taken once it has differed for FILT_LEN samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_f   <= 1'b1;
            b_f   <= 1'b1;
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_p1 == a_f) begin
                a_cnt <= '0;
            end else if (a_cnt == CNT_W'(FILT_LEN - 1)) begin
                a_f   <= a_p1;
                a_cnt <= '0;
            end else begin
                a_cnt <= a_cnt + 1'b1;
            end
            if (b_p1 == b_f) begin
                b_cnt <= '0;
            end else if (b_cnt == CNT_W'(FILT_LEN - 1)) begin
                b_f   <= b_p1;
                b_cnt <= '0;
            end else begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end
`else
    assign a_f = a_p1;
    assign b_f = b_p1;
`endif

    // Gray-code sequences only ever move one phase per sample
    assign illegal = (a_f != a_q) && (b_f != b_q);

    // FSM stage: state, registered pulses and position counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
            pos     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            a_q     <= a_f;
            b_q     <= b_f;
            step_up <= (state == ADD);
            step_dn <= (state == SUB);
            err     <= illegal;
            if (illegal) begin
                state <= IDLE;
                dir   <= 1'b0;
            end else begin
                state <= step_fsm(state, a_f, b_f);
                dir   <= is_right(step_fsm(state, a_f, b_f));
            end
            if (clr) begin
                pos <= '0;
            end else if (state == ADD) begin
                pos <= pos_inc(pos);
            end else if (state == SUB) begin
                pos <= pos_dec(pos);
            end
        end
    end

endmodule

// File: rtl/quad_encoder_array.sv
// Array of NUM_CH independent quadrature decoders; build with QENC_FILTER_EN for
// input glitch filtering.
module quad_encoder_array
    import qenc_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    BTN,
    input  logic [NUM_CH-1:0]       A,
    input  logic [NUM_CH-1:0]       B,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH*POS_W-1:0] pos,
    output logic [NUM_CH-1:0]       step_up,
    output logic [NUM_CH-1:0]       step_dn,
    output logic [NUM_CH-1:0]       dir,
    output logic [NUM_CH-1:0]       err
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        qenc_channel #(
            .POS_W   (POS_W),
            .POS_MAX (POS_MAX),
            .FILT_LEN(FILT_LEN)
        ) u_ch (
            .clk    (clk),
            .rst    (BTN),
            .a      (A[g]),
            .b      (B[g]),
            .clr    (clr[g]),
            .pos    (pos[g*POS_W +: POS_W]),
            .step_up(step_up[g]),
            .step_dn(step_dn[g]),
            .dir    (dir[g]),
            .err    (err[g])
        );
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Scoreboard bench for quad_encoder_array: directed cases plus randomized encoder traffic.
module tb_quad_encoder_array;

    localparam int NUM_CH   = 2;
    localparam int POS_W    = 5;
    localparam int POS_MAX  = 19;
    localparam int FILT_LEN = 4;
`ifdef QENC_FILTER_EN
    localparam int LAT = 4 + FILT_LEN;
`else
    localparam int LAT = 4;
`endif
    localparam int GAP_EXTRA = LAT - 4;

    localparam int K_UP  = 0;
    localparam int K_DN  = 1;
    localparam int K_ERR = 2;

    localparam int T_RIGHT = 0;
    localparam int T_LEFT  = 1;
    localparam int T_RREV  = 2;
    localparam int T_LREV  = 3;
    localparam int T_ILL   = 4;

    typedef struct {
        int kind;
        int p;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    btn;
    logic                    a0, a1, b0, b1;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH*POS_W-1:0] pos;
    logic [NUM_CH-1:0]       step_up, step_dn, dir, err;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int up_cnt [NUM_CH];
    int mpos   [NUM_CH];
    ev_t q0[$];
    ev_t q1[$];

    quad_encoder_array #(
        .NUM_CH  (NUM_CH),
        .POS_W   (POS_W),
        .POS_MAX (POS_MAX),
        .FILT_LEN(FILT_LEN)
    ) dut (
        .clk    (clk),
        .BTN    (btn),
        .A      ({a1, a0}),
        .B      ({b1, b0}),
        .clr    (clr),
        .pos    (pos),
        .step_up(step_up),
        .step_dn(step_dn),
        .dir    (dir),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int pos_of(int ch);
        return int'(pos[ch*POS_W +: POS_W]);
    endfunction

    function automatic int inc(int p);
        return (p + 1) % (POS_MAX + 1);
    endfunction

    function automatic int dec(int p);
        return (p + POS_MAX) % (POS_MAX + 1);
    endfunction

    task automatic push_ev(int ch, int kind, int p);
        ev_t e;
        e.kind = kind;
        e.p    = p;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic set_ab(int ch, logic av, logic bv);
        if (ch == 0) begin
            a0 = av;
            b0 = bv;
        end else begin
            a1 = av;
            b1 = bv;
        end
    endtask

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected outcome comes from what the gesture means, not from how it is decoded
    task automatic run_txn(int ch, int kind, int depth, int gmin, int gmax);
        logic [1:0] seq[$];
        case (kind)
            T_RIGHT: seq = '{2'b10, 2'b00, 2'b01, 2'b11};
            T_LEFT:  seq = '{2'b01, 2'b00, 2'b10, 2'b11};
            T_RREV:  if (depth == 1)      seq = '{2'b10, 2'b11};
                     else if (depth == 2) seq = '{2'b10, 2'b00, 2'b10, 2'b11};
                     else                 seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
            T_LREV:  if (depth == 1)      seq = '{2'b01, 2'b11};
                     else if (depth == 2) seq = '{2'b01, 2'b00, 2'b01, 2'b11};
                     else                 seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
            default: seq = '{2'b00, 2'b11};
        endcase
        if (kind == T_RIGHT) begin
            mpos[ch] = inc(mpos[ch]);
            push_ev(ch, K_UP, mpos[ch]);
        end else if (kind == T_LEFT) begin
            mpos[ch] = dec(mpos[ch]);
            push_ev(ch, K_DN, mpos[ch]);
        end else if (kind == T_ILL) begin
            push_ev(ch, K_ERR, mpos[ch]);
            push_ev(ch, K_ERR, mpos[ch]);
        end
        foreach (seq[i]) begin
            logic [1:0] lv;
            lv = seq[i];
            set_ab(ch, lv[1], lv[0]);
            wait_neg($urandom_range(gmax, gmin));
        end
    endtask

    task automatic random_traffic(int ch, int n);
        for (int i = 0; i < n; i++) begin
            run_txn(ch, $urandom_range(4, 0), $urandom_range(3, 1),
                    2 + GAP_EXTRA, 8 + GAP_EXTRA);
        end
    endtask

    // Monitor: every pulse must match the head of that channel's expected queue
    always @(negedge clk) begin
        if (!btn) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (step_up[ch] || step_dn[ch] || err[ch]) begin
                    int  kind;
                    int  qs;
                    ev_t e;
                    kind = step_up[ch] ? K_UP : (step_dn[ch] ? K_DN : K_ERR);
                    ev_cnt++;
                    if (kind == K_UP) up_cnt[ch]++;
                    qs = (ch == 0) ? q0.size() : q1.size();
                    if (qs == 0) begin
                        check($sformatf("unexpected_event_ch%0d", ch), kind, -1);
                    end else begin
                        if (ch == 0) e = q0.pop_front();
                        else         e = q1.pop_front();
                        check($sformatf("event_kind_ch%0d", ch), kind, e.kind);
                        check($sformatf("event_pos_ch%0d", ch), pos_of(ch), e.p);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int snap;
        for (int i = 0; i < NUM_CH; i++) begin
            up_cnt[i] = 0;
            mpos[i]   = 0;
        end
        btn = 1'b1;
        clr = '0;
        a0 = 1'b1; b0 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        wait_neg(3);
        check("reset_pos0", pos_of(0), 0);
        check("reset_pos1", pos_of(1), 0);
        check("reset_pulses", int'({step_up, step_dn, err}), 0);
        check("reset_dir", int'(dir), 0);
        btn = 1'b0;
        wait_neg(5);

        // Single right cycle on ch0 with mid-cycle dir and latency checks
        mpos[0] = inc(mpos[0]);
        push_ev(0, K_UP, mpos[0]);
        set_ab(0, 1'b1, 1'b0);
        wait_neg(LAT + 2);
        check("dir_in_right_cycle", int'(dir[0]), 1);
        wait_neg(10 - LAT - 2 + GAP_EXTRA);
        set_ab(0, 1'b0, 1'b0);
        wait_neg(10);
        set_ab(0, 1'b0, 1'b1);
        wait_neg(10);
        set_ab(0, 1'b1, 1'b1);
        n = 0;
        while (!step_up[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("step_latency", n, LAT);
        wait_neg(3);
        check("right_pos0", pos_of(0), 1);
        check("right_pos1_untouched", pos_of(1), 0);
        check("dir_after_detent", int'(dir[0]), 0);

        // Left cycle on ch1 from 0 wraps to POS_MAX
        run_txn(1, T_LEFT, 0, 10, 10);
        wait_neg(LAT + 3);
        check("left_wrap_pos1", pos_of(1), POS_MAX);

        // Twenty right cycles from zero
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        mpos[0] = 0;
        check("clr_pos0", pos_of(0), 0);
        snap = up_cnt[0];
        for (int i = 0; i < 20; i++) run_txn(0, T_RIGHT, 0, 2 + GAP_EXTRA, 6 + GAP_EXTRA);
        wait_neg(LAT + 3);
        check("wrap20_pos0", pos_of(0), 0);
        check("wrap20_pulses", up_cnt[0] - snap, 20);

        // Reversal before completion does not count
        snap = ev_cnt;
        run_txn(0, T_RREV, 2, 10, 10);
        wait_neg(LAT + 3);
        check("reversal_no_event", ev_cnt - snap, 0);
        check("reversal_pos0", pos_of(0), 0);
        check("reversal_idle_dir", int'(dir[0]), 0);

        // Clear coinciding with a step: pulse kept, position cleared
        set_ab(0, 1'b1, 1'b0); wait_neg(10);
        set_ab(0, 1'b0, 1'b0); wait_neg(10);
        set_ab(0, 1'b0, 1'b1); wait_neg(10);
        mpos[0] = 0;
        push_ev(0, K_UP, 0);
        set_ab(0, 1'b1, 1'b1);
        wait_neg(LAT - 1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("clr_vs_step_pulse", int'(step_up[0]), 1);
        wait_neg(4);
        check("clr_vs_step_pos0", pos_of(0), 0);

        // Simultaneous fall of both phases is illegal
        push_ev(0, K_ERR, mpos[0]);
        push_ev(0, K_ERR, mpos[0]);
        set_ab(0, 1'b0, 1'b0);
        n = 0;
        while (!err[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("illegal_err_seen", int'(err[0]), 1);
        @(negedge clk);
        check("illegal_err_one_cycle", int'(err[0]), 0);
        wait_neg(10);
        set_ab(0, 1'b1, 1'b1);
        wait_neg(LAT + 4);
        check("illegal_no_count", pos_of(0), mpos[0]);

        // Short glitch on B is discarded
        snap = ev_cnt;
        set_ab(0, 1'b1, 1'b0); wait_neg(2);
        set_ab(0, 1'b1, 1'b1); wait_neg(LAT + 6);
        check("glitch_no_event", ev_cnt - snap, 0);
        check("glitch_pos0", pos_of(0), mpos[0]);

        // Reset asserted mid-cycle (state R2) discards the partial cycle
        run_txn(1, T_RIGHT, 0, 4 + GAP_EXTRA, 6 + GAP_EXTRA);
        wait_neg(LAT + 3);
        set_ab(0, 1'b1, 1'b0); wait_neg(12);
        set_ab(0, 1'b0, 1'b0); wait_neg(12);
        check("r2_dir", int'(dir[0]), 1);
        snap = ev_cnt;
        btn = 1'b1;
        @(negedge clk);
        set_ab(0, 1'b0, 1'b1);
        @(negedge clk);
        set_ab(0, 1'b1, 1'b1);
        wait_neg(2);
        btn = 1'b0;
        mpos[0] = 0;
        mpos[1] = 0;
        wait_neg(LAT + 10);
        check("btn_r2_no_event", ev_cnt - snap, 0);
        check("btn_r2_pos0", pos_of(0), 0);
        check("btn_r2_pos1", pos_of(1), 0);
        check("btn_r2_dir", int'(dir[0]), 0);
        run_txn(0, T_RIGHT, 0, 4 + GAP_EXTRA, 6 + GAP_EXTRA);
        wait_neg(LAT + 3);
        check("resume_after_btn", pos_of(0), 1);

        // Concurrent randomized traffic on both channels
        fork
            random_traffic(0, 30);
            random_traffic(1, 30);
        join
        wait_neg(LAT + 10);
        check("random_pos0", pos_of(0), mpos[0]);
        check("random_pos1", pos_of(1), mpos[1]);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
